// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the opcode-to-format mapping.
package rv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    // SYSTEM carries its CSR address in the I-type field, so it decodes as I.
    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        case (opcode)
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: return IMM_I;
            OP_STORE:                            return IMM_S;
            OP_BRANCH:                           return IMM_B;
            OP_LUI, OP_AUIPC:                    return IMM_U;
            OP_JAL:                              return IMM_J;
            default:                             return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: instruction word in, sign-extended immediate out.
module imm_gen
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt_of(instr[6:0]))
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'h000};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with writeback bypass, load-use stall and ID/EX register.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds the registered ex_illegal flag.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    output logic [4:0]      rf_a1,
    output logic [4:0]      rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_is_load,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic            ex_illegal,
`endif
    output logic            ex_reg_write
);

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic            rs1_used, rs2_used, reg_write_dec, is_load_dec;
    logic            hazard, accept;
    logic [XLEN-1:0] rs1_val, rs2_val, imm;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;

    always_comb begin
        rs1_used      = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
        rs2_used      = opcode inside {OP_REG, OP_STORE, OP_BRANCH};
        is_load_dec   = (opcode == OP_LOAD);
        reg_write_dec = (opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
                                        OP_IMM, OP_REG, OP_SYSTEM}) && (rd != 5'd0);
    end

    // The register file writes on the clock edge, so a same-cycle writeback must be forwarded.
    assign rs1_val = (wb_wen && wb_rd != 5'd0 && wb_rd == rs1) ? wb_data : rf_rd1;
    assign rs2_val = (wb_wen && wb_rd != 5'd0 && wb_rd == rs2) ? wb_data : rf_rd2;

    assign hazard   = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));
    assign id_ready = !hazard && (!ex_valid || ex_ready);
    assign accept   = if_valid && id_ready;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_dec;

    always_comb begin
        illegal_dec = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                       OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_FENCE});
        if (opcode == OP_REG) begin
            if (!(if_instr[31:25] == 7'h00 ||
                  (if_instr[31:25] == 7'h20 && (if_instr[14:12] == 3'd0 || if_instr[14:12] == 3'd5))))
                illegal_dec = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_illegal <= 1'b0;
        else if (flush || (ex_valid && !ex_ready) || hazard || !accept)
            ex_illegal <= ex_illegal;
        else
            ex_illegal <= illegal_dec;
    end
`endif

    // Bubbles only clear ex_valid; the data fields keep their old (don't-care) contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= XLEN'(RESET_PC);
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (ex_valid && !ex_ready) begin
            ex_valid <= ex_valid;
        end else if (hazard) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid     <= 1'b1;
            ex_pc        <= if_pc;
            ex_rs1_val   <= rs1_val;
            ex_rs2_val   <= rs2_val;
            ex_imm       <= imm;
            ex_rd        <= rd;
            ex_rs1       <= rs1;
            ex_rs2       <= rs2;
            ex_opcode    <= opcode;
            ex_funct3    <= if_instr[14:12];
            ex_funct7b5  <= if_instr[30];
            ex_is_load   <= is_load_dec;
            ex_reg_write <= reg_write_dec;
        end else begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, corner sequences, random run vs model.
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, wb_wen, ex_ready, flush;
    logic [31:0] if_instr, if_pc, rf_rd1, rf_rd2, wb_data;
    logic [4:0]  wb_rd;
    logic        id_ready, ex_valid, ex_funct7b5, ex_is_load, ex_reg_write;
    logic [4:0]  rf_a1, rf_a2, ex_rd, ex_rs1, ex_rs2;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        ex_illegal;
`endif

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .ex_illegal(ex_illegal),
`endif
        .ex_reg_write(ex_reg_write)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic        f7b5, is_load, reg_write, illegal;
    } ex_t;

    ex_t mdl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediate recomputed with plain arithmetic from the instruction's bit fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        int op;
        op = int'(ins & 32'h7F);
        v = 0;
        case (op)
            7'h67, 7'h03, 7'h13, 7'h73: begin
                v = int'(ins >> 20);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                v = int'(ins >> 25) * 32 + int'((ins >> 7) & 31);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                v = int'((ins >> 31) & 1) * 4096 + int'((ins >> 7) & 1) * 2048 +
                    int'((ins >> 25) & 63) * 32 + int'((ins >> 8) & 15) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
            7'h6F: begin
                v = int'((ins >> 31) & 1) * (1 << 20) + int'((ins >> 12) & 255) * 4096 +
                    int'((ins >> 20) & 1) * 2048 + int'((ins >> 21) & 1023) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == 7'h33 || op == 7'h23 || op == 7'h63);
    endfunction

    function automatic ex_t ref_decode();
        ex_t e;
        logic [6:0] f7;
        e.valid   = 1'b1;
        e.pc      = if_pc;
        e.opcode  = if_instr[6:0];
        e.rd      = if_instr[11:7];
        e.f3      = if_instr[14:12];
        e.rs1     = if_instr[19:15];
        e.rs2     = if_instr[24:20];
        e.f7b5    = if_instr[30];
        f7        = if_instr[31:25];
        e.rs1v    = (wb_wen && wb_rd != 0 && wb_rd == e.rs1) ? wb_data : rf_rd1;
        e.rs2v    = (wb_wen && wb_rd != 0 && wb_rd == e.rs2) ? wb_data : rf_rd2;
        e.imm     = ref_imm(if_instr);
        e.is_load = (e.opcode == 7'h03);
        e.reg_write = (e.rd != 0) && (e.opcode inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                                                       7'h13, 7'h33, 7'h73});
        e.illegal = !(e.opcode inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                       7'h13, 7'h33, 7'h73, 7'h0F});
        if (e.opcode == 7'h33 && !(f7 == 7'h00 || (f7 == 7'h20 && (e.f3 == 0 || e.f3 == 5))))
            e.illegal = 1'b1;
        return e;
    endfunction

    function automatic logic mdl_hazard();
        return mdl.valid && mdl.is_load && mdl.rd != 0 &&
               ((uses_rs1(if_instr[6:0]) && mdl.rd == if_instr[19:15]) ||
                (uses_rs2(if_instr[6:0]) && mdl.rd == if_instr[24:20]));
    endfunction

    task automatic mdl_reset();
        mdl = '0;
        mdl.pc = RST_PC;
    endtask

    task automatic check_ex(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(mdl.valid));
        if (mdl.valid) begin
            chk({tag, ".pc"},   ex_pc, mdl.pc);
            chk({tag, ".rs1v"}, ex_rs1_val, mdl.rs1v);
            chk({tag, ".rs2v"}, ex_rs2_val, mdl.rs2v);
            chk({tag, ".imm"},  ex_imm, mdl.imm);
            chk({tag, ".regs"}, 32'({ex_rd, ex_rs1, ex_rs2}), 32'({mdl.rd, mdl.rs1, mdl.rs2}));
            chk({tag, ".ctl"},  32'({ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_reg_write}),
                                32'({mdl.opcode, mdl.f3, mdl.f7b5, mdl.is_load, mdl.reg_write}));
`ifdef DECODE_ILLEGAL_TRAP_EN
            chk({tag, ".illegal"}, 32'(ex_illegal), 32'(mdl.illegal));
`endif
        end
    endtask

    // Inputs are driven just after a rising edge; this checks the combinational side,
    // advances one clock and compares ID/EX against the model.
    task automatic cycle(input string tag);
        ex_t nxt;
        logic hz, rdy;
        #1;
        hz  = mdl_hazard();
        rdy = !hz && (!mdl.valid || ex_ready);
        chk({tag, ".id_ready"}, 32'(id_ready), 32'(rdy));
        chk({tag, ".rf_addr"}, 32'({rf_a1, rf_a2}), 32'({if_instr[19:15], if_instr[24:20]}));
        nxt = mdl;
        if (flush)                    nxt.valid = 1'b0;
        else if (mdl.valid && !ex_ready) nxt = mdl;
        else if (hz)                  nxt.valid = 1'b0;
        else if (if_valid && rdy)     nxt = ref_decode();
        else                          nxt.valid = 1'b0;
        @(posedge clk);
        mdl = nxt;
        #1;
        check_ex(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    typedef struct {
        logic [31:0] instr, rd1, rd2;
        logic        wen;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] exp_rs1v, exp_imm;
        logic [4:0]  exp_rd;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] held_pc;
        logic [6:0]  ops[12];

        vecs[0] = '{32'hFFD08293, 32'd10, 32'd0, 1'b0, 5'd0, 32'h0, 32'd10, 32'hFFFFFFFD, 5'd5, 1'b1};
        vecs[1] = '{32'h002081B3, 32'h11, 32'h22, 1'b1, 5'd1, 32'h55, 32'h55, 32'h0, 5'd3, 1'b1};
        vecs[2] = '{32'h002081B3, 32'h11, 32'h22, 1'b1, 5'd0, 32'h55, 32'h11, 32'h0, 5'd3, 1'b1};
        vecs[3] = '{32'h80000063, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'hFFFFF000, 5'd0, 1'b0};
        vecs[4] = '{32'h002000EF, 32'h7, 32'h0, 1'b0, 5'd0, 32'h0, 32'h7, 32'h2, 5'd1, 1'b1};
        vecs[5] = '{32'h123453B7, 32'h9, 32'h0, 1'b0, 5'd0, 32'h0, 32'h9, 32'h12345000, 5'd7, 1'b1};
        vecs[6] = '{32'hFE20AE23, 32'h3, 32'h4, 1'b1, 5'd1, 32'hAA, 32'hAA, 32'hFFFFFFFC, 5'd28, 1'b0};
        vecs[7] = '{32'h0000028B, 32'h5, 32'h0, 1'b0, 5'd0, 32'h0, 32'h5, 32'h0, 5'd5, 1'b0};
        vecs[8] = '{32'h00108013, 32'h6, 32'h0, 1'b0, 5'd0, 32'h0, 32'h6, 32'h1, 5'd0, 1'b0};

        rst_n = 1'b0; drive(1'b0, 32'h0, 32'h0);
        rf_rd1 = 0; rf_rd2 = 0; wb_wen = 0; wb_rd = 0; wb_data = 0; ex_ready = 1; flush = 0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", 32'(ex_valid), 32'd0);
        chk("reset.pc", ex_pc, RST_PC);
        chk("reset.fields", ex_rs1_val | ex_rs2_val | ex_imm | 32'({ex_rd, ex_rs1, ex_rs2}) |
            32'({ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_reg_write}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].instr, 32'h200 + 32'(i * 4));
            rf_rd1 = vecs[i].rd1; rf_rd2 = vecs[i].rd2;
            wb_wen = vecs[i].wen; wb_rd = vecs[i].wrd; wb_data = vecs[i].wdata;
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.rs1v", i), ex_rs1_val, vecs[i].exp_rs1v);
            chk($sformatf("vec%0d.imm", i), ex_imm, vecs[i].exp_imm);
            chk($sformatf("vec%0d.rd", i), 32'(ex_rd), 32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d.rw", i), 32'(ex_reg_write), 32'(vecs[i].exp_rw));
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (i == 7) chk("vec7.illegal", 32'(ex_illegal), 32'd1);
`endif
            $display("[TB] vec %0d instr %h imm %h rd %0d", i, vecs[i].instr, ex_imm, ex_rd);
        end
        wb_wen = 0;

        // Load-use: LW x7 then ADD x8,x7,x1 stalls once; LW then LUI x7 does not.
        drive(1'b1, 32'h00012383, 32'h300); cycle("lw");
        drive(1'b1, 32'h00138433, 32'h304);
        #1 chk("lu.stall_ready", 32'(id_ready), 32'd0);
        cycle("lu.bubble");
        chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
        cycle("lu.accept");
        chk("lu.add_rd", 32'(ex_rd), 32'd8);
        drive(1'b1, 32'h00012383, 32'h308); cycle("lw2");
        drive(1'b1, 32'h123453B7, 32'h30C);
        #1 chk("lu.lui_ready", 32'(id_ready), 32'd1);
        cycle("lu.lui");
        $display("[TB] load-use sequence done");

        // Backpressure: contents frozen for three cycles.
        drive(1'b1, 32'hFFD08293, 32'h400); cycle("bp.load");
        held_pc = 32'h400;
        ex_ready = 0;
        drive(1'b1, 32'h002081B3, 32'h404);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp.ready", 32'(id_ready), 32'd0);
            cycle("bp.hold");
            chk("bp.pc", ex_pc, held_pc);
        end
        ex_ready = 1;
        cycle("bp.release");

        // Flush drops the offered instruction.
        flush = 1; drive(1'b1, 32'h00108013, 32'h500);
        cycle("flush");
        chk("flush.valid", 32'(ex_valid), 32'd0);
        flush = 0;
        $display("[TB] backpressure/flush sequence done");

        // Asynchronous reset in the middle of a cycle with ID/EX occupied.
        drive(1'b1, 32'hFFD08293, 32'h600); cycle("prerst");
        chk("prerst.valid", 32'(ex_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(ex_valid), 32'd0);
        chk("arst.pc", ex_pc, RST_PC);
        chk("arst.rw", 32'(ex_reg_write), 32'd0);
        mdl_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        $display("[TB] async reset sequence done");

        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0B, 7'h00};
        for (int n = 0; n < 250; n++) begin
            logic [31:0] ins;
            logic [6:0]  f7;
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 11)];
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            f7 = ($urandom_range(0, 3) == 0) ? 7'h01 : (($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00);
            if (ins[6:0] == 7'h33) ins[31:25] = f7;
            drive(1'($urandom_range(0, 3) != 0), ins, $urandom & 32'hFFFF_FFFC);
            rf_rd1 = $urandom; rf_rd2 = $urandom;
            wb_wen = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
            ex_ready = 1'($urandom_range(0, 3) != 0);
            flush = 1'($urandom_range(0, 15) == 0);
            cycle($sformatf("rnd%0d", n));
            $display("[TB] rnd %0d instr %h v %0b rdy %0b fl %0b -> ex_valid %0b",
                     n, ins, if_valid, ex_ready, flush, ex_valid);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
